// File: rtl/psum_pkg.sv
// Shared defaults, FSM encoding and saturation limits for the partial-sum accumulator.
package psum_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 25;
  localparam int unsigned ACC_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOut  = 2'd2
  } state_e;

  function automatic longint sat_max(int unsigned dw);
    return (longint'(1) << (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(int unsigned dw);
    return -(longint'(1) << (dw - 1));
  endfunction

  localparam longint SAT_MAX_DEF = sat_max(DATA_WIDTH_DEF);
  localparam longint SAT_MIN_DEF = sat_min(DATA_WIDTH_DEF);

endpackage

// File: rtl/psum_accum_if.sv
// Upstream FIFO read port and downstream valid/ready result port of psum_accum.
interface psum_accum_if #(
  parameter int unsigned DATA_WIDTH = psum_pkg::DATA_WIDTH_DEF
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_rd_en,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/psum_sat.sv
// Clamps a signed accumulator value into the signed DATA_WIDTH output range.
module psum_sat
  import psum_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [DATA_WIDTH-1:0] sat_o
);

  localparam logic signed [ACC_WIDTH-1:0] Hi = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] Lo = ACC_WIDTH'(sat_min(DATA_WIDTH));

  always_comb begin
    sat_o = acc_i[DATA_WIDTH-1:0];
    if (acc_i > Hi) begin
      sat_o = Hi[DATA_WIDTH-1:0];
    end else if (acc_i < Lo) begin
      sat_o = Lo[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Pops acc_len psums per output from an upstream FIFO, sums them, and hands out num_out
// saturated results over valid/ready; done pulses in the first IDLE cycle after the last one.
module psum_accum
  import psum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       acc_len,
  input  logic [7:0]       num_out,
  output logic             busy,
  output logic             done,
  psum_accum_if.master     bus
);

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum;
  logic [7:0]                   issued_q, issued_d;
  logic [7:0]                   recv_q, recv_d;
  logic [7:0]                   len_q, len_d;
  logic [7:0]                   rem_q, rem_d;
  logic                         rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         done_q, done_d;
  logic signed [DATA_WIDTH-1:0] sat_val;
  logic                         rd_en;

  // Gated by rst so no word is popped from a FIFO that is being cleared in the same cycle.
  assign rd_en   = !rst && (state_q == StRun) && !bus.fifo_empty && (issued_q < len_q);
  assign acc_sum = acc_q + {{(ACC_WIDTH - DATA_WIDTH){bus.fifo_data[DATA_WIDTH-1]}},
                            bus.fifo_data};

  psum_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat (
    .acc_i (acc_sum),
    .sat_o (sat_val)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    issued_d    = issued_q;
    recv_d      = recv_q;
    len_d       = len_q;
    rem_d       = rem_q;
    rd_pend_d   = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (acc_len != 8'd0) && (num_out != 8'd0)) begin
          state_d  = StRun;
          len_d    = acc_len;
          rem_d    = num_out;
          acc_d    = '0;
          issued_d = 8'd0;
          recv_d   = 8'd0;
        end
      end
      StRun: begin
        rd_pend_d = rd_en;
        if (rd_en) begin
          issued_d = issued_q + 8'd1;
        end
        // The final word is summed and saturated straight into the output register.
        if (rd_pend_q) begin
          acc_d  = acc_sum;
          recv_d = recv_q + 8'd1;
          if (recv_q + 8'd1 == len_q) begin
            state_d     = StOut;
            out_data_d  = sat_val;
            out_valid_d = 1'b1;
          end
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          issued_d    = 8'd0;
          recv_d      = 8'd0;
          rem_d       = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      issued_q    <= 8'd0;
      recv_q      <= 8'd0;
      len_q       <= 8'd0;
      rem_q       <= 8'd0;
      rd_pend_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      issued_q    <= issued_d;
      recv_q      <= recv_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      rd_pend_q   <= rd_pend_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;

endmodule
